// File: rtl/fetch_pc_stage_pkg.sv
// Shared fetch-stage definitions: word size, PC step, NOP encoding and the IF/ID bundle
// consumed by the ID stage and the EX branch-resolve logic.
package fetch_pc_stage_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] NOP_ENC = 32'h00000000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } if_id_t;

    // Fetch addresses are always word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_stage_if.sv
// Fetch-side bus: BTB lookup (PC out, prediction back) and the combinational
// instruction-memory read port.
interface fetch_pc_stage_if;
    import fetch_pc_stage_pkg::*;

    logic [XLEN-1:0] btb_pc;
    logic            btb_access;
    logic [XLEN-1:0] btb_predict_pc;
    logic [1:0]      btb_state;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output btb_pc, btb_access, imem_addr,
        input  btb_predict_pc, btb_state, imem_rdata
    );

    modport slave (
        input  btb_pc, btb_access, imem_addr,
        output btb_predict_pc, btb_state, imem_rdata
    );

endinterface

// File: rtl/fetch_pc_stage_if_id_reg.sv
// IF/ID pipeline register with load, hold and flush. A flush only kills the
// instruction; PC/target fields keep their last values.
module fetch_pc_stage_if_id_reg
    import fetch_pc_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg       <= '0;
            q_reg.instr <= NOP_INSTR;
        end else if (flush) begin
            q_reg.valid      <= 1'b0;
            q_reg.instr      <= NOP_INSTR;
            q_reg.pred_taken <= 1'b0;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: owns the PC, steers it with the BTB prediction or an EX
// redirect, and loads the fetched word into IF/ID.
module fetch_pc_stage
    import fetch_pc_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h00000000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_ENC,
    parameter int              CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    fetch_pc_stage_if.master       bus,
    output logic                   if_id_valid,
    output logic [XLEN-1:0]        if_id_instr,
    output logic [XLEN-1:0]        if_id_pc,
    output logic [XLEN-1:0]        if_id_pc_plus4,
    output logic                   if_id_pred_taken,
    output logic [XLEN-1:0]        if_id_pred_target,
    output logic [CNT_W-1:0]       redirect_count
);

    logic [XLEN-1:0]  pc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  next_pc;
    logic             pred_taken;
    if_id_t           if_id_d;
    if_id_t           if_id_q;

    assign pred_taken = bus.btb_state[1];
    assign seq_pc     = pc_reg + PC_STEP;
    assign next_pc    = pred_taken ? bus.btb_predict_pc : seq_pc;

    assign bus.btb_pc     = pc_reg;
    assign bus.imem_addr  = pc_reg;
    assign bus.btb_access = ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg  <= RESET_PC;
            cnt_reg <= '0;
        end else if (redirect) begin
            pc_reg <= word_align(redirect_pc);
            if (~&cnt_reg)
                cnt_reg <= cnt_reg + CNT_W'(1);
        end else if (!stall) begin
            pc_reg <= word_align(next_pc);
        end
    end

    // The unaligned next_pc is kept as the target so EX compares against what was predicted.
    always_comb begin
        if_id_d             = '0;
        if_id_d.valid       = 1'b1;
        if_id_d.instr       = bus.imem_rdata;
        if_id_d.pc          = pc_reg;
        if_id_d.pc_plus4    = seq_pc;
        if_id_d.pred_taken  = pred_taken;
        if_id_d.pred_target = next_pc;
    end

    fetch_pc_stage_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .load  (~stall),
        .flush (redirect),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign if_id_valid       = if_id_q.valid;
    assign if_id_instr       = if_id_q.instr;
    assign if_id_pc          = if_id_q.pc;
    assign if_id_pc_plus4    = if_id_q.pc_plus4;
    assign if_id_pred_taken  = if_id_q.pred_taken;
    assign if_id_pred_target = if_id_q.pred_target;
    assign redirect_count    = cnt_reg;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Bench for fetch_pc_stage: vector table through a scoreboard queue, plus a
// narrow-counter instance for redirect saturation.
module tb_fetch_pc_stage;
    import fetch_pc_stage_pkg::*;

    localparam logic [31:0] NOP_T = 32'h00000013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid, if_id_pred_taken;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, if_id_pred_target;
    logic [15:0] redirect_count;

    logic        b_reset, b_stall, b_redirect;
    logic [31:0] b_redirect_pc;
    logic        b_valid, b_pred_taken;
    logic [31:0] b_instr, b_pc, b_pc_plus4, b_pred_target;
    logic [1:0]  b_count;

    fetch_pc_stage_if bus_a ();
    fetch_pc_stage_if bus_b ();

    fetch_pc_stage #(
        .RESET_PC  (32'h00000000),
        .NOP_INSTR (NOP_T),
        .CNT_W     (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .bus               (bus_a),
        .if_id_valid       (if_id_valid),
        .if_id_instr       (if_id_instr),
        .if_id_pc          (if_id_pc),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_pred_taken  (if_id_pred_taken),
        .if_id_pred_target (if_id_pred_target),
        .redirect_count    (redirect_count)
    );

    fetch_pc_stage #(
        .RESET_PC  (32'h00000000),
        .NOP_INSTR (NOP_T),
        .CNT_W     (2)
    ) dut_narrow (
        .clk               (clk),
        .reset             (b_reset),
        .stall             (b_stall),
        .redirect          (b_redirect),
        .redirect_pc       (b_redirect_pc),
        .bus               (bus_b),
        .if_id_valid       (b_valid),
        .if_id_instr       (b_instr),
        .if_id_pc          (b_pc),
        .if_id_pc_plus4    (b_pc_plus4),
        .if_id_pred_taken  (b_pred_taken),
        .if_id_pred_target (b_pred_target),
        .redirect_count    (b_count)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic [1:0]  st;
        logic [31:0] ppc;
        logic [31:0] rdata;
        logic [31:0] e_pc;
        logic        e_v;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic [31:0] e_p4;
        logic        e_pt;
        logic [31:0] e_tgt;
        logic [15:0] e_cnt;
    } vec_t;

    int   tests  = 0;
    int   failed = 0;
    vec_t vecs[$];
    vec_t exp_q[$];
    logic [1:0] cnt_q[$];

    function automatic vec_t mk(
        input logic rst, input logic stl, input logic rd, input logic [31:0] rpc,
        input logic [1:0] st, input logic [31:0] ppc, input logic [31:0] rdata,
        input logic [31:0] e_pc, input logic e_v, input logic [31:0] e_instr,
        input logic [31:0] e_ipc, input logic [31:0] e_p4, input logic e_pt,
        input logic [31:0] e_tgt, input logic [15:0] e_cnt);
        vec_t v;
        v.rst = rst; v.stall = stl; v.redirect = rd; v.rpc = rpc;
        v.st = st; v.ppc = ppc; v.rdata = rdata;
        v.e_pc = e_pc; v.e_v = e_v; v.e_instr = e_instr; v.e_ipc = e_ipc;
        v.e_p4 = e_p4; v.e_pt = e_pt; v.e_tgt = e_tgt; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        reset               = v.rst;
        stall               = v.stall;
        redirect            = v.redirect;
        redirect_pc         = v.rpc;
        bus_a.btb_state     = v.st;
        bus_a.btb_predict_pc = v.ppc;
        bus_a.imem_rdata    = v.rdata;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("v%0d pc", idx), bus_a.btb_pc, e.e_pc);
        chk($sformatf("v%0d imem_addr", idx), bus_a.imem_addr, e.e_pc);
        chk($sformatf("v%0d btb_access", idx), {31'd0, bus_a.btb_access}, {31'd0, ~e.rst});
        chk($sformatf("v%0d valid", idx), {31'd0, if_id_valid}, {31'd0, e.e_v});
        chk($sformatf("v%0d instr", idx), if_id_instr, e.e_instr);
        chk($sformatf("v%0d if_pc", idx), if_id_pc, e.e_ipc);
        chk($sformatf("v%0d pc_plus4", idx), if_id_pc_plus4, e.e_p4);
        chk($sformatf("v%0d pred_taken", idx), {31'd0, if_id_pred_taken}, {31'd0, e.e_pt});
        chk($sformatf("v%0d pred_target", idx), if_id_pred_target, e.e_tgt);
        chk($sformatf("v%0d redirect_count", idx), {16'd0, redirect_count}, {16'd0, e.e_cnt});
        $display("[TB] vec %0d rst=%0b stl=%0b rd=%0b pc=%h if_pc=%h instr=%h v=%0b pt=%0b cnt=%0d",
                 idx, e.rst, e.stall, e.redirect, bus_a.btb_pc, if_id_pc, if_id_instr,
                 if_id_valid, if_id_pred_taken, redirect_count);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        bus_a.btb_state = 2'b00; bus_a.btb_predict_pc = '0; bus_a.imem_rdata = '0;
        b_reset = 1'b1; b_stall = 1'b0; b_redirect = 1'b0; b_redirect_pc = '0;
        bus_b.btb_state = 2'b00; bus_b.btb_predict_pc = '0; bus_b.imem_rdata = '0;

        //         rst stl rd  rpc           st     ppc           rdata          pc            v  instr         if_pc         plus4         pt tgt           cnt
        vecs.push_back(mk(1, 0, 0, 32'h0,        2'b00, 32'h0,        32'h0,         32'h0,        0, NOP_T,        32'h0,        32'h0,        0, 32'h0,        16'd0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 32'h0,        32'h20080001,  32'h4,        1, 32'h20080001, 32'h0,        32'h4,        0, 32'h4,        16'd0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 32'h0,        32'h20080001,  32'h8,        1, 32'h20080001, 32'h4,        32'h8,        0, 32'h8,        16'd0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b10, 32'h24,       32'hAAAA0003,  32'h24,       1, 32'hAAAA0003, 32'h8,        32'hC,        1, 32'h24,       16'd0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b11, 32'hE,        32'hBBBB0004,  32'hC,        1, 32'hBBBB0004, 32'h24,       32'h28,       1, 32'hE,        16'd0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        2'b10, 32'h500,      32'hCCCC0005,  32'hC,        1, 32'hBBBB0004, 32'h24,       32'h28,       1, 32'hE,        16'd0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        2'b00, 32'h600,      32'hCCCC0006,  32'hC,        1, 32'hBBBB0004, 32'h24,       32'h28,       1, 32'hE,        16'd0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b01, 32'h700,      32'hDDDD0007,  32'h10,       1, 32'hDDDD0007, 32'hC,        32'h10,       0, 32'h10,       16'd0));
        vecs.push_back(mk(0, 1, 1, 32'h40,       2'b10, 32'h80,       32'hEEEE0008,  32'h40,       0, NOP_T,        32'hC,        32'h10,       0, 32'h10,       16'd1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b11, 32'h44,       32'hF0000009,  32'h44,       1, 32'hF0000009, 32'h40,       32'h44,       1, 32'h44,       16'd1));
        vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFC, 2'b10, 32'h90,       32'h12345678,  32'hFFFFFFFC, 0, NOP_T,        32'h40,       32'h44,       0, 32'h44,       16'd2));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 32'h0,        32'h0A0A0A0A,  32'h0,        1, 32'h0A0A0A0A, 32'hFFFFFFFC, 32'h0,        0, 32'h0,        16'd2));
        vecs.push_back(mk(0, 0, 1, 32'h43,       2'b00, 32'h0,        32'h0B0B0B0B,  32'h40,       0, NOP_T,        32'hFFFFFFFC, 32'h0,        0, 32'h0,        16'd3));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 32'h0,        32'h13131313,  32'h44,       1, 32'h13131313, 32'h40,       32'h44,       0, 32'h44,       16'd3));
        // Reset coinciding with redirect and stall, then restart from RESET_PC.
        vecs.push_back(mk(1, 1, 1, 32'h80,       2'b10, 32'h200,      32'h14141414,  32'h0,        0, NOP_T,        32'h0,        32'h0,        0, 32'h0,        16'd0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 32'h0,        32'h15151515,  32'h4,        1, 32'h15151515, 32'h0,        32'h4,        0, 32'h4,        16'd0));

        foreach (vecs[i]) apply(i, vecs[i]);

        // Narrow counter: five consecutive redirects saturate at 2'b11.
        @(posedge clk);
        #1;
        b_reset = 1'b0;
        b_redirect = 1'b1;
        b_redirect_pc = 32'h43;
        for (int k = 0; k < 5; k++) begin
            cnt_q.push_back((k < 3) ? 2'(k + 1) : 2'b11);
            @(posedge clk);
            #1;
            begin
                logic [1:0] ec;
                ec = cnt_q.pop_front();
                chk($sformatf("narrow cnt r%0d", k), {30'd0, b_count}, {30'd0, ec});
                chk($sformatf("narrow pc r%0d", k), bus_b.btb_pc, 32'h40);
                $display("[TB] narrow redirect %0d pc=%h cnt=%0d", k, bus_b.btb_pc, b_count);
            end
        end
        b_redirect = 1'b0;

        if (exp_q.size() != 0 || cnt_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size() + cnt_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
